spi_master_gen: RTL

//  Parametrised SPI master: one command word (write/read opcode), then LEN data words on a selected chip-select.

---
 rtl/spi_master_gen.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_gen.sv
// rtl/spi_master_gen.sv - SPI master: command word plus LEN data words on one chip select
//
// Purpose: shifts one command word (CMD_WR or CMD_RD) followed by len data words,
// MSB first, in any of the four SPI modes, with a programmable SCLK half-period.
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   trig                  start pulse, accepted only in IDLE
//   wr, mode, cs_sel, len transaction attributes, latched at trig
//   wdat / wdat_req       write word supply; wdat captured 1 clk after wdat_req
//   rdat / rdat_vld       received data word and its 1-clk valid pulse
//   busy, trans_over      transaction in progress / 1-clk end-of-transaction pulse
//   csn, sclk, mosi, miso SPI pins
module spi_master_gen #(
  parameter int DW     = 8,
  parameter int DIV    = 4,
  parameter int NCS    = 4,
  parameter int LEN_W  = 8,
  parameter logic [DW-1:0] CMD_WR = 'h3c,
  parameter logic [DW-1:0] CMD_RD = 'h5b,
  localparam int CSW   = (NCS > 1) ? $clog2(NCS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic             wr,
  input  logic [1:0]       mode,
  input  logic [CSW-1:0]   cs_sel,
  input  logic [LEN_W-1:0] len,
  input  logic [DW-1:0]    wdat,
  output logic             wdat_req,
  output logic [DW-1:0]    rdat,
  output logic             rdat_vld,
  output logic             busy,
  output logic             trans_over,
  output logic [NCS-1:0]   csn,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso
);

  localparam int HW  = $clog2(DIV + 1);
  localparam int BW  = $clog2(DW);
  localparam int WCW = LEN_W + 1;
  localparam logic [HW-1:0] HLAST = HW'(DIV - 1);
  localparam logic [BW-1:0] BLAST = BW'(DW - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t           r_state;
  logic [HW-1:0]    r_hcnt;
  logic [BW-1:0]    r_bcnt;
  logic [WCW-1:0]   r_wcnt;
  logic             r_lead;     // next SCLK edge is a leading edge
  logic             r_wr;
  logic             r_cpol;
  logic             r_cpha;
  logic [LEN_W-1:0] r_len;
  logic [DW-1:0]    r_sreg;     // transmit bits still to launch, MSB next
  logic [DW-1:0]    r_rsh;      // receive shift register
  logic [DW-1:0]    r_hold;     // next write word from the client
  logic             r_req_d;
  logic             r_rpend;    // full data word received, publish next clk
  logic             r_wdat_req;
  logic [DW-1:0]    r_rdat;
  logic             r_rdat_vld;
  logic             r_busy;
  logic             r_trans_over;
  logic [NCS-1:0]   r_csn;
  logic             r_sclk;
  logic             r_mosi;

  logic             w_hend;
  logic             w_sample;
  logic             w_last_bit;
  logic             w_last_word;
  logic [WCW-1:0]   w_len_x;
  logic [DW-1:0]    w_next;
  logic [DW-1:0]    w_cmd;

  assign w_hend      = (r_hcnt == HLAST);
  // Sample on leading edges for CPHA=0, on trailing edges for CPHA=1.
  assign w_sample    = r_lead ^ r_cpha;
  assign w_last_bit  = (r_bcnt == BLAST);
  assign w_len_x     = {1'b0, r_len};
  assign w_last_word = (r_wcnt == w_len_x);
  // Read transfers keep mosi high through the data words.
  assign w_next      = r_wr ? r_hold : '1;
  assign w_cmd       = wr ? CMD_WR : CMD_RD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_hcnt       <= '0;
      r_bcnt       <= '0;
      r_wcnt       <= '0;
      r_lead       <= 1'b1;
      r_wr         <= 1'b0;
      r_cpol       <= 1'b0;
      r_cpha       <= 1'b0;
      r_len        <= '0;
      r_sreg       <= '0;
      r_rsh        <= '0;
      r_hold       <= '0;
      r_req_d      <= 1'b0;
      r_rpend      <= 1'b0;
      r_wdat_req   <= 1'b0;
      r_rdat       <= '0;
      r_rdat_vld   <= 1'b0;
      r_busy       <= 1'b0;
      r_trans_over <= 1'b0;
      r_csn        <= '1;
      r_sclk       <= 1'b0;
      r_mosi       <= 1'b1;
    end else begin
      r_wdat_req   <= 1'b0;
      r_rdat_vld   <= 1'b0;
      r_trans_over <= 1'b0;
      r_req_d      <= r_wdat_req;
      if (r_req_d) r_hold <= wdat;
      if (r_rpend) begin
        r_rdat     <= r_rsh;
        r_rdat_vld <= 1'b1;
        r_rpend    <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (trig) begin
            r_wr   <= wr;
            r_cpol <= mode[1];
            r_cpha <= mode[0];
            r_len  <= len;
            r_sclk <= mode[1];
            for (int i = 0; i < NCS; i++) r_csn[i] <= !(cs_sel == CSW'(i));
            r_busy <= 1'b1;
            r_hcnt <= '0;
            r_bcnt <= '0;
            r_wcnt <= '0;
            r_lead <= 1'b1;
            r_rsh  <= '0;
            if (mode[0]) begin
              r_sreg <= w_cmd;
            end else begin
              // CPHA=0 presents the first bit before the first edge.
              r_mosi     <= w_cmd[DW-1];
              r_sreg     <= {w_cmd[DW-2:0], 1'b0};
              r_wdat_req <= wr && (len != '0);
            end
            r_state <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (w_hend) begin
            r_hcnt  <= '0;
            r_state <= S_SHIFT;
          end else begin
            r_hcnt <= r_hcnt + HW'(1);
          end
        end

        S_SHIFT: begin
          if (w_hend) begin
            r_hcnt <= '0;
            r_sclk <= ~r_sclk;
            r_lead <= ~r_lead;
            if (w_sample) begin
              r_rsh <= {r_rsh[DW-2:0], miso};
              if (w_last_bit && !r_wr && (r_wcnt != '0)) r_rpend <= 1'b1;
            end else if (r_cpha) begin
              // CPHA=1 launches on leading edges; a word starts at bit 0.
              if (r_bcnt == '0) r_wdat_req <= r_wr && (r_wcnt < w_len_x);
              if ((r_bcnt == '0) && (r_wcnt != '0)) begin
                r_mosi <= w_next[DW-1];
                r_sreg <= {w_next[DW-2:0], 1'b0};
              end else begin
                r_mosi <= r_sreg[DW-1];
                r_sreg <= {r_sreg[DW-2:0], 1'b0};
              end
            end else if (!w_last_bit) begin
              r_mosi <= r_sreg[DW-1];
              r_sreg <= {r_sreg[DW-2:0], 1'b0};
            end else if (!w_last_word) begin
              // CPHA=0 word boundary: first bit of the next word on this trailing edge.
              r_mosi     <= w_next[DW-1];
              r_sreg     <= {w_next[DW-2:0], 1'b0};
              r_wdat_req <= r_wr && ((r_wcnt + WCW'(1)) < w_len_x);
            end
            if (!r_lead) begin
              if (w_last_bit) begin
                r_bcnt <= '0;
                r_wcnt <= r_wcnt + WCW'(1);
                if (w_last_word) r_state <= S_HOLD;
              end else begin
                r_bcnt <= r_bcnt + BW'(1);
              end
            end
          end else begin
            r_hcnt <= r_hcnt + HW'(1);
          end
        end

        S_HOLD: begin
          if (w_hend) begin
            r_hcnt       <= '0;
            r_csn        <= '1;
            r_mosi       <= 1'b1;
            r_trans_over <= (DIV == 1);
            r_state      <= S_GAP;
          end else begin
            r_hcnt <= r_hcnt + HW'(1);
          end
        end

        S_GAP: begin
          if (w_hend) begin
            r_hcnt  <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_hcnt       <= r_hcnt + HW'(1);
            r_trans_over <= ((r_hcnt + HW'(1)) == HLAST);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wdat_req   = r_wdat_req;
  assign rdat       = r_rdat;
  assign rdat_vld   = r_rdat_vld;
  assign busy       = r_busy;
  assign trans_over = r_trans_over;
  assign csn        = r_csn;
  assign sclk       = r_sclk;
  assign mosi       = r_mosi;

endmodule
